operand_loader: RTL and testbench



---
 rtl/operand_loader.sv | 156 +++++++++++++++
 tb/tb_operand_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand capture front-end: synchronises and debounces four push-buttons and
// loads the synchronised switch nibble into operand A/B on each clean press.
module operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] pb,
    input  logic [3:0] c,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [3:0] loaded,
    output logic       valid,
    output logic       update
);

    localparam int unsigned    CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DM1 = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    logic [3:0] pb_s1_q;
    logic [3:0] pb_s2_q;
    logic [3:0] c_s1_q;
    logic [3:0] c_s2_q;
    logic       update_q;
    logic [3:0] write;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pb_s1_q  <= '0;
            pb_s2_q  <= '0;
            c_s1_q   <= '0;
            c_s2_q   <= '0;
            update_q <= 1'b0;
        end else begin
            pb_s1_q  <= pb;
            pb_s2_q  <= pb_s1_q;
            c_s1_q   <= c;
            c_s2_q   <= c_s1_q;
            update_q <= |write;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        state_e        state_q;
        state_e        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [3:0]    nib_q;
        logic          loaded_q;
        logic          wr;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // cnt holds the number of qualifying samples already seen, so the
        // transition fires when the current sample is the D-th one.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (pb_s2_q[g]) begin
                        if (DM1 == '0) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!pb_s2_q[g]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DM1) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!pb_s2_q[g]) begin
                        if (DM1 == '0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (pb_s2_q[g]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == DM1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            wr = 1'b0;
            if (pb_s2_q[g]) begin
                if (state_q == PRESS_WAIT && cnt_q == DM1) begin
                    wr = 1'b1;
                end else if (state_q == IDLE && DM1 == '0) begin
                    wr = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                nib_q    <= '0;
                loaded_q <= 1'b0;
            end else if (wr) begin
                nib_q    <= c_s2_q;
                loaded_q <= 1'b1;
            end
        end

        assign write[g]  = wr;
        assign loaded[g] = loaded_q;
    end

    assign a      = {g_ch[1].nib_q, g_ch[0].nib_q};
    assign b      = {g_ch[3].nib_q, g_ch[2].nib_q};
    assign valid  = &loaded;
    assign update = update_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader (D=4): hand-computed vector table plus randomized
// traffic compared every cycle against a run-length debounce model.
module tb_operand_loader;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] pb;
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] loaded;
    logic       valid;
    logic       update;

    int n_checks = 0;
    int n_fail   = 0;

    operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .pb     (pb),
        .c      (c),
        .a      (a),
        .b      (b),
        .loaded (loaded),
        .valid  (valid),
        .update (update)
    );

    always #5 clk = ~clk;

    // Model: each button has a debounced level; it flips once D consecutive
    // synchronised samples disagree with it, and a flip to 1 loads a nibble.
    logic [3:0] m_s1, m_s2, m_c1, m_c2;
    logic       m_lvl [4];
    int         m_run [4];
    logic [3:0] m_nib [4];
    logic [3:0] m_loaded;
    logic       m_upd;

    task automatic model_step();
        if (!rstn) begin
            m_s1 = '0; m_s2 = '0; m_c1 = '0; m_c2 = '0;
            m_loaded = '0; m_upd = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_lvl[i] = 1'b0; m_run[i] = 0; m_nib[i] = '0;
            end
        end else begin
            m_upd = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_s2[i]) begin
                            m_nib[i]    = m_c2;
                            m_loaded[i] = 1'b1;
                            m_upd       = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1; m_s1 = pb;
            m_c2 = m_c1; m_c1 = c;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int upd_seen;

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_a", {24'd0, a}, {24'd0, m_nib[1], m_nib[0]});
        check("model_b", {24'd0, b}, {24'd0, m_nib[3], m_nib[2]});
        check("model_loaded", {28'd0, loaded}, {28'd0, m_loaded});
        check("model_valid", {31'd0, valid}, {31'd0, &m_loaded});
        check("model_update", {31'd0, update}, {31'd0, m_upd});
        if (update === 1'b1) upd_seen++;
    endtask

    typedef struct {
        logic       rstn;
        logic [3:0] pb;
        logic [3:0] c;
        int         cyc;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] el;
        int         eu;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [3:0] p, logic [3:0] cv, int n,
                                logic [7:0] ea, logic [7:0] eb, logic [3:0] el, int eu);
        vec_t v;
        v.rstn = r; v.pb = p; v.c = cv; v.cyc = n;
        v.ea = ea; v.eb = eb; v.el = el; v.eu = eu;
        return v;
    endfunction

    initial begin
        rstn = 1'b0;
        pb   = 4'hF;
        c    = 4'h9;

        // reset with buttons held
        vt.push_back(mk(0, 4'hF, 4'h9, 3,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h0, 4'hA, 4,  8'h00, 8'h00, 4'b0000, 0));
        // clean load on pb[1]: write lands exactly at edge D+2, no reload while held
        vt.push_back(mk(1, 4'h2, 4'hA, 5,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h2, 4'hA, 1,  8'hA0, 8'h00, 4'b0010, 1));
        vt.push_back(mk(1, 4'h2, 4'hA, 14, 8'hA0, 8'h00, 4'b0010, 0));
        vt.push_back(mk(1, 4'h0, 4'hA, 10, 8'hA0, 8'h00, 4'b0010, 0));
        // bounce rejection then stable press
        vt.push_back(mk(0, 4'h0, 4'h0, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h3, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h0, 4'h3, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h3, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h0, 4'h3, 10, 8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h3, 10, 8'h03, 8'h00, 4'b0001, 1));
        vt.push_back(mk(1, 4'h0, 4'h3, 10, 8'h03, 8'h00, 4'b0001, 0));
        // full load 5,A,C,3
        vt.push_back(mk(0, 4'h0, 4'h0, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h5, 10, 8'h05, 8'h00, 4'b0001, 1));
        vt.push_back(mk(1, 4'h0, 4'h5, 10, 8'h05, 8'h00, 4'b0001, 0));
        vt.push_back(mk(1, 4'h2, 4'hA, 10, 8'hA5, 8'h00, 4'b0011, 1));
        vt.push_back(mk(1, 4'h0, 4'hA, 10, 8'hA5, 8'h00, 4'b0011, 0));
        vt.push_back(mk(1, 4'h4, 4'hC, 10, 8'hA5, 8'h0C, 4'b0111, 1));
        vt.push_back(mk(1, 4'h0, 4'hC, 10, 8'hA5, 8'h0C, 4'b0111, 0));
        vt.push_back(mk(1, 4'h8, 4'h3, 10, 8'hA5, 8'h3C, 4'b1111, 1));
        vt.push_back(mk(1, 4'h0, 4'h3, 10, 8'hA5, 8'h3C, 4'b1111, 0));
        // simultaneous press: one pulse
        vt.push_back(mk(0, 4'h0, 4'h0, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'hC, 4'h7, 10, 8'h00, 8'h77, 4'b1100, 1));
        vt.push_back(mk(1, 4'h0, 4'h7, 10, 8'h00, 8'h77, 4'b1100, 0));
        // reset at edge 4 of a debounce: full D+2 restarts after release
        vt.push_back(mk(0, 4'h0, 4'h0, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h6, 3,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(0, 4'h1, 4'h6, 1,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h6, 5,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h1, 4'h6, 1,  8'h06, 8'h00, 4'b0001, 1));
        vt.push_back(mk(1, 4'h0, 4'h6, 10, 8'h06, 8'h00, 4'b0001, 0));
        // glitch boundary: D-1 samples reject, D samples load
        vt.push_back(mk(0, 4'h0, 4'h0, 2,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h4, 4'hE, 3,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h0, 4'hE, 8,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h4, 4'hE, 4,  8'h00, 8'h00, 4'b0000, 0));
        vt.push_back(mk(1, 4'h0, 4'hE, 4,  8'h00, 8'h0E, 4'b0100, 1));
        vt.push_back(mk(1, 4'h0, 4'hE, 10, 8'h00, 8'h0E, 4'b0100, 0));
        // overwrite of a loaded nibble
        vt.push_back(mk(1, 4'h4, 4'h1, 10, 8'h00, 8'h01, 4'b0100, 1));
        vt.push_back(mk(1, 4'h0, 4'h1, 10, 8'h00, 8'h01, 4'b0100, 0));

        for (int k = 0; k < vt.size(); k++) begin
            rstn = vt[k].rstn;
            pb   = vt[k].pb;
            c    = vt[k].c;
            upd_seen = 0;
            for (int n = 0; n < vt[k].cyc; n++) tick();
            check($sformatf("vec%0d_a", k), {24'd0, a}, {24'd0, vt[k].ea});
            check($sformatf("vec%0d_b", k), {24'd0, b}, {24'd0, vt[k].eb});
            check($sformatf("vec%0d_loaded", k), {28'd0, loaded}, {28'd0, vt[k].el});
            check($sformatf("vec%0d_valid", k), {31'd0, valid}, {31'd0, &vt[k].el});
            check($sformatf("vec%0d_updates", k), upd_seen, vt[k].eu);
        end

        for (int s = 0; s < 400; s++) begin
            rstn = ($urandom_range(0, 39) != 0);
            pb   = 4'($urandom_range(0, 15));
            c    = 4'($urandom_range(0, 15));
            for (int n = 0; n < int'($urandom_range(1, 9)); n++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
